// File: rtl/mavg_core.sv
// Moving average over the last DEPTH W-bit samples using a running-sum accumulator.
// Optional build macro: MAVG_ROUND_EN selects round-half-up instead of truncation.
module mavg_core #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  localparam int unsigned L  = $clog2(DEPTH);
  localparam int unsigned SW = W + L;
  localparam int unsigned CW = L + 1;

  typedef enum logic {
    FILL,
    RUN
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   x_q;
  logic           v_q;
  logic [W-1:0]   tap_q [DEPTH];
  logic [SW-1:0]  sum_q, sum_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]  avg_full;
  logic [W-1:0]   avg;
  logic [W-1:0]   y_d;

  // Oldest tap is always a previously added sample, so the difference never underflows.
  always_comb begin
    sum_d = sum_q + SW'(x_q) - SW'(tap_q[DEPTH-1]);
  end

  always_comb begin
`ifdef MAVG_ROUND_EN
    avg_full = sum_q + SW'(DEPTH / 2);
`else
    avg_full = sum_q;
`endif
    avg = W'(avg_full >> L);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = '0;
    case (state_q)
      FILL: begin
        if (v_q) begin
          cnt_d = cnt_q + CW'(1);
        end
        if (cnt_d == CW'(DEPTH)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        y_d = avg;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      x_q     <= '0;
      v_q     <= 1'b0;
      sum_q   <= '0;
      cnt_q   <= '0;
      y       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tap_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      x_q      <= x;
      v_q      <= 1'b1;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      y        <= y_d;
      tap_q[0] <= x_q;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        tap_q[i] <= tap_q[i-1];
      end
    end
  end

endmodule
